// File: rtl/mt_rand_receiver_if.sv
// Signal bundle between the Mersenne-Twister word stream, the receive FIFO and its consumer.
// Downstream handshake: a word transfers on a rising edge where out_valid && out_ready; out_valid never waits on out_ready.
interface mt_rand_receiver_if #(
  parameter int DATA_SIZE     = 32,
  parameter int ADDR_SIZE     = 4,
  parameter int DROP_CNT_SIZE = 16
);
  logic [DATA_SIZE-1:0]     rand_in;
  logic                     rand_in_valid;
  logic                     flush;
  logic                     clear_stats;
  logic [DATA_SIZE-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ADDR_SIZE:0]       level;
  logic [31:0]              rx_count;
  logic [DROP_CNT_SIZE-1:0] drop_count;
  logic                     overflow;

  modport master (
    output rand_in, rand_in_valid, flush, clear_stats, out_ready,
    input  out_data, out_valid, level, rx_count, drop_count, overflow
  );

  modport slave (
    input  rand_in, rand_in_valid, flush, clear_stats, out_ready,
    output out_data, out_valid, level, rx_count, drop_count, overflow
  );
endinterface

// File: rtl/mt_rand_receiver.sv
// Receive FIFO for the backpressure-free random word stream, re-presented as ready/valid,
// with accept and saturating drop statistics.
module mt_rand_receiver #(
  parameter int DATA_SIZE     = 32,
  parameter int ADDR_SIZE     = 4,
  parameter int DROP_CNT_SIZE = 16
) (
  input logic               clk,
  input logic               reset,
  mt_rand_receiver_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]       FULL_LEVEL = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0]       LEVEL_ONE  = (ADDR_SIZE + 1)'(1);
  localparam logic [ADDR_SIZE-1:0]     PTR_ONE    = ADDR_SIZE'(1);
  localparam logic [DROP_CNT_SIZE-1:0] DROP_ONE   = DROP_CNT_SIZE'(1);
  localparam logic [DROP_CNT_SIZE-1:0] DROP_MAX   = '1;

  logic [DATA_SIZE-1:0]     mem_q [DEPTH];
  logic [ADDR_SIZE-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_SIZE:0]       level_q, level_d;
  logic [31:0]              rx_count_q, rx_count_d;
  logic [DROP_CNT_SIZE-1:0] drop_count_q, drop_count_d;
  logic                     overflow_q, overflow_d;
  logic                     full, pop, accept, drop;

  always_comb begin
    full   = (level_q == FULL_LEVEL);
    // A pop during flush is ignored, so it must not free a slot for the incoming word either.
    pop    = (level_q != '0) && bus.out_ready && !bus.flush;
    accept = bus.rand_in_valid && !bus.flush && (!full || pop);
    drop   = bus.rand_in_valid && !bus.flush && full && !pop;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rx_count_d = rx_count_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (accept) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        rx_count_d = rx_count_q + 32'd1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (accept && !pop) level_d = level_q + LEVEL_ONE;
      else if (pop && !accept) level_d = level_q - LEVEL_ONE;
    end

    drop_count_d = drop_count_q;
    overflow_d   = overflow_q | drop;
    if (bus.clear_stats) begin
      drop_count_d = drop ? DROP_ONE : '0;
      overflow_d   = drop;
    end else if (drop && drop_count_q != DROP_MAX) begin
      drop_count_d = drop_count_q + DROP_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= bus.rand_in;
  end

  assign bus.out_data   = (level_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign bus.out_valid  = (level_q != '0);
  assign bus.level      = level_q;
  assign bus.rx_count   = rx_count_q;
  assign bus.drop_count = drop_count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_mt_rand_receiver.sv
// Bench for mt_rand_receiver: vector table, scoreboard of accepted words, and corner-case sequences.
module tb_mt_rand_receiver;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mt_rand_receiver_if #(.DATA_SIZE(32), .ADDR_SIZE(4), .DROP_CNT_SIZE(16)) b ();
  mt_rand_receiver_if #(.DATA_SIZE(32), .ADDR_SIZE(4), .DROP_CNT_SIZE(4))  b2 ();

  mt_rand_receiver #(.DATA_SIZE(32), .ADDR_SIZE(4), .DROP_CNT_SIZE(16)) dut (
    .clk(clk), .reset(rst), .bus(b.slave));
  mt_rand_receiver #(.DATA_SIZE(32), .ADDR_SIZE(4), .DROP_CNT_SIZE(4)) dut_sat (
    .clk(clk), .reset(rst), .bus(b2.slave));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          m_rx   = 0;
  int          m_drop = 0;
  logic        m_ovf  = 1'b0;
  int          n_pop  = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        f;
    logic        c;
    int          e_level;
    logic        e_valid;
    logic [31:0] e_data;
    int          e_rx;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the main instance, scoring pops and updating the model; returns at posedge+1.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f, input logic c);
    bit was_full, pop_m, drop_m;
    @(negedge clk);
    b.rand_in = d; b.rand_in_valid = v; b.out_ready = r; b.flush = f; b.clear_stats = c;
    was_full = (exp_q.size() == DEPTH);
    pop_m    = (exp_q.size() != 0) && r && !f;
    drop_m   = v && !f && was_full && !pop_m;
    if (pop_m) begin
      check("pop_data", 64'(b.out_data), 64'(exp_q[0]));
      void'(exp_q.pop_front());
      n_pop++;
    end
    if (f) exp_q.delete();
    else if (v && !drop_m) begin
      exp_q.push_back(d);
      m_rx++;
    end
    if (c) begin
      m_drop = drop_m ? 1 : 0;
      m_ovf  = drop_m;
    end else if (drop_m) begin
      if (m_drop < 65535) m_drop++;
      m_ovf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_level"}, 64'(b.level), 64'(exp_q.size()));
    check({tag, "_valid"}, 64'(b.out_valid), 64'(exp_q.size() != 0));
    check({tag, "_rx"},    64'(b.rx_count), 64'(m_rx));
    check({tag, "_drop"},  64'(b.drop_count), 64'(m_drop));
    check({tag, "_ovf"},   64'(b.overflow), 64'(m_ovf));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 64'(b.out_valid), 64'(0));
  endtask

  task automatic step2(input logic v, input logic [31:0] d, input logic c);
    @(negedge clk);
    b2.rand_in = d; b2.rand_in_valid = v; b2.clear_stats = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rx0, drop0, pop0;
    b.rand_in = '0; b.rand_in_valid = 0; b.out_ready = 0; b.flush = 0; b.clear_stats = 0;
    b2.rand_in = '0; b2.rand_in_valid = 0; b2.out_ready = 0; b2.flush = 0; b2.clear_stats = 0;

    // Vector table: inputs for one cycle, outputs expected after that edge.
    vecs.push_back('{1, 32'hDEADBEEF, 0, 0, 0, 1, 1, 32'hDEADBEEF, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        1});
    vecs.push_back('{1, 32'hA1,       0, 0, 0, 1, 1, 32'hA1,       2});
    vecs.push_back('{1, 32'hA2,       0, 0, 0, 2, 1, 32'hA1,       3});
    vecs.push_back('{1, 32'hA3,       0, 0, 0, 3, 1, 32'hA1,       4});
    vecs.push_back('{1, 32'hA4,       0, 0, 0, 4, 1, 32'hA1,       5});
    vecs.push_back('{1, 32'hA5,       0, 0, 0, 5, 1, 32'hA1,       6});
    vecs.push_back('{1, 32'hBAD,      1, 1, 0, 0, 0, 32'h0,        6});
    vecs.push_back('{1, 32'h77,       0, 0, 0, 1, 1, 32'h77,       7});
    vecs.push_back('{1, 32'h88,       1, 0, 0, 1, 1, 32'h88,       8});
    vecs.push_back('{0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        8});

    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 64'(b.level), 64'(0));
    check("rst_valid", 64'(b.out_valid), 64'(0));
    check("rst_data",  64'(b.out_data), 64'(0));
    check("rst_rx",    64'(b.rx_count), 64'(0));
    check("rst_drop",  64'(b.drop_count), 64'(0));
    check("rst_ovf",   64'(b.overflow), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].f, vecs[i].c);
      check("vec_level", 64'(b.level), 64'(vecs[i].e_level));
      check("vec_valid", 64'(b.out_valid), 64'(vecs[i].e_valid));
      check("vec_data",  64'(b.out_data), 64'(vecs[i].e_data));
      check("vec_rx",    64'(b.rx_count), 64'(vecs[i].e_rx));
      check("vec_drop",  64'(b.drop_count), 64'(0));
    end

    // Overflow: 17 words into an empty FIFO with no consumer.
    rx0 = m_rx;
    for (int i = 1; i <= 17; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    check("ovf_level", 64'(b.level), 64'(16));
    check("ovf_drop",  64'(b.drop_count), 64'(1));
    check("ovf_flag",  64'(b.overflow), 64'(1));
    check("ovf_rx",    64'(b.rx_count - 32'(rx0)), 64'(16));
    check("ovf_head",  64'(b.out_data), 64'(1));

    // Full with a simultaneous pop: 99 is taken, level holds.
    step(1'b1, 32'd99, 1'b1, 1'b0, 1'b0);
    check("fullpop_level", 64'(b.level), 64'(16));
    check("fullpop_drop",  64'(b.drop_count), 64'(1));
    check_model("fullpop");
    drain();

    // Flush and clear_stats together on a partly filled FIFO.
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h5555, 1'b0, 1'b1, 1'b1);
    check("flushclr_level", 64'(b.level), 64'(0));
    check("flushclr_drop",  64'(b.drop_count), 64'(0));
    check("flushclr_ovf",   64'(b.overflow), 64'(0));
    check_model("flushclr");

    // Back-to-back burst with an always-ready consumer.
    rx0 = m_rx; drop0 = m_drop;
    for (int i = 0; i < 624; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    drain();
    check("burst_rx",   64'(b.rx_count - 32'(rx0)), 64'(624));
    check("burst_drop", 64'(b.drop_count), 64'(drop0));
    check_model("burst");

    // Same burst with the consumer ready every other cycle.
    drop0 = m_drop; pop0 = n_pop;
    for (int i = 0; i < 624; i++) step(1'b1, $urandom, 1'(i % 2), 1'b0, 1'b0);
    drain();
    check("toggle_some_drop", 64'(b.drop_count > 16'(drop0)), 64'(1));
    check("toggle_sum", 64'(int'(b.drop_count) - drop0 + (n_pop - pop0)), 64'(624));
    check_model("toggle");

    // clear_stats alone, then clear_stats coinciding with a drop.
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check("clr_drop", 64'(b.drop_count), 64'(0));
    check("clr_ovf",  64'(b.overflow), 64'(0));
    for (int i = 0; i < 16; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
    check("clrdrop_drop", 64'(b.drop_count), 64'(1));
    check("clrdrop_ovf",  64'(b.overflow), 64'(1));
    check_model("clrdrop");
    drain();

    // Saturation on the 4-bit drop counter instance.
    for (int i = 0; i < 16; i++) step2(1'b1, 32'(i), 1'b0);
    check("sat_full", 64'(b2.level), 64'(16));
    for (int i = 0; i < 20; i++) step2(1'b1, 32'(i), 1'b0);
    check("sat_drop", 64'(b2.drop_count), 64'(15));
    check("sat_ovf",  64'(b2.overflow), 64'(1));
    step2(1'b0, 32'h0, 1'b1);
    check("sat_clr_drop", 64'(b2.drop_count), 64'(0));
    check("sat_clr_ovf",  64'(b2.overflow), 64'(0));
    step2(1'b1, 32'hF, 1'b1);
    check("sat_clrdrop", 64'(b2.drop_count), 64'(1));
    check("sat_clrdrop_ovf", 64'(b2.overflow), 64'(1));
    step2(1'b0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_level", 64'(b.level), 64'(0));
    check("arst_valid", 64'(b.out_valid), 64'(0));
    check("arst_data",  64'(b.out_data), 64'(0));
    check("arst_rx",    64'(b.rx_count), 64'(0));
    check("arst_drop",  64'(b.drop_count), 64'(0));
    check("arst_ovf",   64'(b.overflow), 64'(0));
    check("arst_sat_level", 64'(b2.level), 64'(0));
    exp_q.delete(); m_rx = 0; m_drop = 0; m_ovf = 1'b0;
    b.rand_in_valid = 1'b0; b.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);
    check("post_rst_data", 64'(b.out_data), 64'(32'hCAFEF00D));
    check_model("post_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
